fir_coef_loader: RTL and testbench
==================================

FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 The block SHALL have parameter NT, default 16, meaning number of FIR taps (2..64).
REQ-002 The block SHALL have parameter NCFWIDTH, default 16, meaning signed coefficient width.
REQ-003 The block SHALL have parameter AW, default 6, meaning tap address width, with 2**AW >= NT.
REQ-004 clk  input  1  single clock; all logic posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ena  input  1  sample strobe shared with the FIR; swaps occur only on ena=1 cycles.
REQ-007 wr_en  input  1  write strobe into shadow bank.
REQ-008 wr_addr  input  AW  tap index for write.
REQ-009 wr_data  input  NCFWIDTH  signed coefficient value.
REQ-010 commit  input  1  request to transfer the shadow bank into the active bank.
REQ-011 busy  output  1  high while a commit is pending or swapping.
REQ-012 addr_err  output  1  sticky flag: write with wr_addr >= NT occurred.
REQ-013 coeff_concat  output  NT*NCFWIDTH  active bank; tap i at bits [(i+1)*NCFWIDTH-1 : i*NCFWIDTH].
REQ-014 coef_valid  output  1  high once at least one commit has completed.
REQ-015 coef_update  output  1  one-cycle pulse in the cycle coeff_concat changes.

Function
REQ-016 The shadow bank SHALL hold NT registers of NCFWIDTH bits, written when wr_en=1, busy=0, wr_addr<NT.
REQ-017 Writes with wr_addr >= NT SHALL be dropped and SHALL set addr_err, which clears only on reset.
REQ-018 Writes while busy=1 SHALL be dropped without setting any flag.
REQ-019 The FSM SHALL have states IDLE, PEND, SWAP.
REQ-020 IDLE -> PEND on commit=1, wherever busy=0.
REQ-021 PEND -> SWAP on the first cycle with ena=1, counting the cycle after commit.
REQ-022 SWAP -> IDLE after one cycle.
REQ-023 In SWAP, all NT taps SHALL copy shadow to active atomically in that single cycle.
REQ-024 coef_update SHALL pulse and coef_valid SHALL set in SWAP.
REQ-025 busy SHALL be 1 in PEND and SWAP, 0 in IDLE; commit while busy=1 SHALL be ignored.
REQ-026 With wr_en and commit in the same IDLE cycle, the write SHALL land and be included in the swap.
REQ-027 Latency, commit to updated coeff_concat, SHALL be 2 cycles when ena is held high; otherwise it waits for the next ena=1 plus 1 cycle.
REQ-028 The shadow bank SHALL be retained after swap so partial rewrites are incremental.

Reset
REQ-029 reset SHALL clear to zero: shadow bank, active bank (coeff_concat=0), coef_valid, coef_update, busy, addr_err; FSM -> IDLE.
REQ-030 reset asserted in PEND or SWAP SHALL abort the commit; the active bank reads zero on the cycle after reset.

Configuration
REQ-031 With macro FIR_COEF_READBACK_EN defined, the block SHALL add ports rd_en (input 1), rd_addr (input AW) and rd_data (output NCFWIDTH).
REQ-032 With FIR_COEF_READBACK_EN defined, rd_data SHALL return the shadow value 1 cycle after rd_en.
REQ-033 With FIR_COEF_READBACK_EN defined, rd_data SHALL read 0 for rd_addr >= NT and SHALL reset to 0.
REQ-034 Without FIR_COEF_READBACK_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Verification (NT=4, NCFWIDTH=16)
REQ-035 Write taps 0..3 = 100,-200,300,-400, commit with ena=1 -> coeff_concat=0xFE70_012C_FF38_0064 two cycles after commit; coef_update pulses once; coef_valid=1.
REQ-036 ena=0 for 5 cycles after commit -> busy=1 and coeff_concat unchanged throughout; swap occurs 1 cycle after ena rises.
REQ-037 wr_addr=5 with data 7 -> addr_err=1 and shadow unchanged; addr_err stays 1 until reset.
REQ-038 Write tap 2=55 during PEND -> dropped; after swap, tap 2 holds the pre-commit value.
REQ-039 Same-cycle wr_en (tap 1=9) and commit -> active tap 1=9 after swap.
REQ-040 reset pulse in PEND -> coeff_concat=0, busy=0, coef_valid=0; with FIR_COEF_READBACK_EN, rd_addr=0 returns 0.

Source files
------------

// File: rtl/fir_coef_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_coef_loader_if
//  Purpose  : Bundles the coefficient-loader sample strobe, shadow write port,
//             commit request and active-bank status into one interface.
//  Ports    : master drives ena / wr_en / wr_addr / wr_data / commit
//             (and rd_en / rd_addr when FIR_COEF_READBACK_EN is defined);
//             slave (the loader) drives busy / addr_err / coeff_concat /
//             coef_valid / coef_update (and rd_data with readback).
//  Macro    : FIR_COEF_READBACK_EN adds the shadow readback signals.
//  Revision : 1.0  initial release
// ============================================================================
interface fir_coef_loader_if #(
  parameter int NT       = 16,
  parameter int NCFWIDTH = 16,
  parameter int AW       = 6
);
  logic                   ena;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [NCFWIDTH-1:0]    wr_data;
  logic                   commit;
  logic                   busy;
  logic                   addr_err;
  logic [NT*NCFWIDTH-1:0] coeff_concat;
  logic                   coef_valid;
  logic                   coef_update;
`ifdef FIR_COEF_READBACK_EN
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic [NCFWIDTH-1:0]    rd_data;

  modport master (
    output ena, wr_en, wr_addr, wr_data, commit, rd_en, rd_addr,
    input  busy, addr_err, coeff_concat, coef_valid, coef_update, rd_data
  );
  modport slave (
    input  ena, wr_en, wr_addr, wr_data, commit, rd_en, rd_addr,
    output busy, addr_err, coeff_concat, coef_valid, coef_update, rd_data
  );
`else
  modport master (
    output ena, wr_en, wr_addr, wr_data, commit,
    input  busy, addr_err, coeff_concat, coef_valid, coef_update
  );
  modport slave (
    input  ena, wr_en, wr_addr, wr_data, commit,
    output busy, addr_err, coeff_concat, coef_valid, coef_update
  );
`endif
endinterface
`default_nettype wire

// File: rtl/fir_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module   : fir_coef_loader
//  Purpose  : Double-buffered FIR coefficient store. Coefficients are written
//             one tap at a time into a shadow bank; a commit copies the whole
//             shadow bank into the active bank atomically, aligned to the FIR
//             sample strobe, so the filter never sees a half-updated set.
//  Ports    : clk         - single clock, rising edge
//             reset       - synchronous, active-high
//             bus (slave) - ena, wr_en/wr_addr/wr_data, commit in;
//                           busy, addr_err, coeff_concat, coef_valid,
//                           coef_update out (rd_* with readback enabled)
//  Macro    : FIR_COEF_READBACK_EN - adds a registered shadow-bank read port.
//  Revision : 1.0  initial release
// ============================================================================
module fir_coef_loader #(
  parameter int NT       = 16,
  parameter int NCFWIDTH = 16,
  parameter int AW       = 6
) (
  input  wire                clk,
  input  wire                reset,
  fir_coef_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  // NT widened by one bit so an all-ones wr_addr still compares correctly.
  localparam logic [AW:0] c_nt_ext = (AW+1)'(NT);

  state_t                 state_q,    state_d;
  logic [NCFWIDTH-1:0]    shadow_q [NT];
  logic [NCFWIDTH-1:0]    shadow_d [NT];
  logic [NT*NCFWIDTH-1:0] active_q,   active_d;
  logic                   busy_q,     busy_d;
  logic                   addr_err_q, addr_err_d;
  logic                   valid_q,    valid_d;
  logic                   update_q,   update_d;
`ifdef FIR_COEF_READBACK_EN
  logic [NCFWIDTH-1:0]    rd_data_q,  rd_data_d;
`endif

  logic w_addr_ok;
  assign w_addr_ok = ({1'b0, bus.wr_addr} < c_nt_ext);

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    busy_d     = busy_q;
    addr_err_d = addr_err_q;
    valid_d    = valid_q;
    update_d   = 1'b0;

    // Shadow writes are only accepted in IDLE; a write in the same cycle as
    // a commit lands before the copy because the copy happens no earlier
    // than the following cycle.
    if (bus.wr_en && !busy_q) begin
      if (w_addr_ok) begin
        for (int i = 0; i < NT; i++) begin
          if (bus.wr_addr == AW'(i)) begin
            shadow_d[i] = bus.wr_data;
          end
        end
      end else begin
        addr_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.commit) begin
          state_d = ST_PEND;
          busy_d  = 1'b1;
        end
      end
      ST_PEND: begin
        // The copy is registered on entry to SWAP, so the new bank and the
        // update pulse are both visible during the SWAP cycle itself.
        if (bus.ena) begin
          state_d  = ST_SWAP;
          update_d = 1'b1;
          valid_d  = 1'b1;
          for (int i = 0; i < NT; i++) begin
            active_d[i*NCFWIDTH +: NCFWIDTH] = shadow_q[i];
          end
        end
      end
      ST_SWAP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef FIR_COEF_READBACK_EN
  // Out-of-range addresses match no tap and therefore return zero.
  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < NT; i++) begin
        if (bus.rd_addr == AW'(i)) begin
          rd_data_d = shadow_q[i];
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < NT; i++) begin
        shadow_q[i] <= '0;
      end
      active_q   <= '0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
      valid_q    <= 1'b0;
      update_q   <= 1'b0;
`ifdef FIR_COEF_READBACK_EN
      rd_data_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
      valid_q    <= valid_d;
      update_q   <= update_d;
`ifdef FIR_COEF_READBACK_EN
      rd_data_q  <= rd_data_d;
`endif
    end
  end

  assign bus.busy         = busy_q;
  assign bus.addr_err     = addr_err_q;
  assign bus.coeff_concat = active_q;
  assign bus.coef_valid   = valid_q;
  assign bus.coef_update  = update_q;
`ifdef FIR_COEF_READBACK_EN
  assign bus.rd_data      = rd_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_coef_loader
//  Purpose  : Self-checking bench for fir_coef_loader (NT=4, NCFWIDTH=16).
//             A shadow-bank model produces the expected active bank at each
//             commit; the value is queued and compared when coef_update fires.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_coef_loader;
  localparam int NT = 4;
  localparam int W  = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_coef_loader_if #(.NT(NT), .NCFWIDTH(W), .AW(AW)) bus_if ();

  fir_coef_loader #(.NT(NT), .NCFWIDTH(W), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0]    sh [NT];
  logic [NT*W-1:0] exp_q [$];
  logic [NT*W-1:0] exp_v;
  logic [NT*W-1:0] active_model;
  bit              seen;
  int              cyc;

  function automatic logic [NT*W-1:0] pack_model();
    logic [NT*W-1:0] v;
    for (int i = 0; i < NT; i++) v[i*W +: W] = sh[i];
    return v;
  endfunction

  task automatic idle_inputs();
    bus_if.ena     = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.wr_addr = '0;
    bus_if.wr_data = '0;
    bus_if.commit  = 1'b0;
`ifdef FIR_COEF_READBACK_EN
    bus_if.rd_en   = 1'b0;
    bus_if.rd_addr = '0;
`endif
  endtask

  task automatic write_tap(input int a, input logic [W-1:0] d, input bit track);
    @(negedge clk);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = AW'(a);
    bus_if.wr_data = d;
    if (track) sh[a] = d;
    @(negedge clk);
    bus_if.wr_en   = 1'b0;
  endtask

  // Returns at the negedge that shows the first PEND cycle.
  task automatic pulse_commit(input logic ena_v);
    @(negedge clk);
    bus_if.commit = 1'b1;
    bus_if.ena    = ena_v;
    exp_q.push_back(pack_model());
    @(negedge clk);
    bus_if.commit = 1'b0;
  endtask

  task automatic wait_update(input int max_cyc, output bit s, output int c);
    s = 1'b0;
    c = 0;
    while (!s && c < max_cyc) begin
      @(negedge clk);
      c++;
      if (bus_if.coef_update === 1'b1) s = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NT; i++) sh[i] = '0;
    active_model = '0;
    @(negedge clk);
    n_cmp++; if (bus_if.coeff_concat !== '0) begin n_err++; $display("FAIL reset_coeff: got %h want 0", bus_if.coeff_concat); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.coef_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus_if.coef_valid); end
    n_cmp++; if (bus_if.coef_update !== 1'b0) begin n_err++; $display("FAIL reset_update: got %b want 0", bus_if.coef_update); end
    n_cmp++; if (bus_if.addr_err !== 1'b0) begin n_err++; $display("FAIL reset_addr_err: got %b want 0", bus_if.addr_err); end
  endtask

  task automatic test_basic_swap();
    write_tap(0, W'(100),  1);
    write_tap(1, W'(-200), 1);
    write_tap(2, W'(300),  1);
    write_tap(3, W'(-400), 1);
    pulse_commit(1'b1);
    n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL basic_pend_busy: got %b want 1", bus_if.busy); end
    n_cmp++; if (bus_if.coeff_concat !== active_model) begin n_err++; $display("FAIL basic_pend_hold: got %h want %h", bus_if.coeff_concat, active_model); end
    wait_update(10, seen, cyc);
    n_cmp++;
    if (!seen || cyc != 1) begin
      n_err++; $display("FAIL basic_latency: seen=%b cycles-after-pend=%0d want seen=1 cycles=1", seen, cyc);
    end
    if (seen && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      active_model = exp_v;
      n_cmp++; if (bus_if.coeff_concat !== exp_v) begin n_err++; $display("FAIL basic_coeff: got %h want %h", bus_if.coeff_concat, exp_v); end
      n_cmp++; if (bus_if.coeff_concat !== 64'hFE70_012C_FF38_0064) begin n_err++; $display("FAIL basic_const: got %h want fe70012cff380064", bus_if.coeff_concat); end
      n_cmp++; if (bus_if.coef_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", bus_if.coef_valid); end
      n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL basic_swap_busy: got %b want 1", bus_if.busy); end
    end
    @(negedge clk);
    n_cmp++; if (bus_if.coef_update !== 1'b0) begin n_err++; $display("FAIL basic_pulse_width: got %b want 0", bus_if.coef_update); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b want 0", bus_if.busy); end
  endtask

`ifdef FIR_COEF_READBACK_EN
  task automatic test_readback();
    for (int i = 0; i <= NT; i++) begin
      @(negedge clk);
      bus_if.rd_en   = 1'b1;
      bus_if.rd_addr = (i == NT) ? AW'(5) : AW'(i);
      @(negedge clk);
      bus_if.rd_en   = 1'b0;
      n_cmp++;
      if (i < NT) begin
        if (bus_if.rd_data !== sh[i]) begin n_err++; $display("FAIL readback_tap%0d: got %h want %h", i, bus_if.rd_data, sh[i]); end
      end else begin
        if (bus_if.rd_data !== '0) begin n_err++; $display("FAIL readback_oob: got %h want 0", bus_if.rd_data); end
      end
    end
  endtask
`endif

  task automatic test_ena_stall();
    write_tap(0, W'(11), 1);
    pulse_commit(1'b0);
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL stall_busy_c%0d: got %b want 1", k, bus_if.busy); end
      n_cmp++; if (bus_if.coeff_concat !== active_model) begin n_err++; $display("FAIL stall_hold_c%0d: got %h want %h", k, bus_if.coeff_concat, active_model); end
      @(negedge clk);
    end
    bus_if.ena = 1'b1;
    wait_update(10, seen, cyc);
    n_cmp++;
    if (!seen || cyc != 1) begin n_err++; $display("FAIL stall_latency: seen=%b cycles=%0d want seen=1 cycles=1", seen, cyc); end
    if (seen && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      active_model = exp_v;
      n_cmp++; if (bus_if.coeff_concat !== exp_v) begin n_err++; $display("FAIL stall_coeff: got %h want %h", bus_if.coeff_concat, exp_v); end
    end
  endtask

  task automatic test_addr_err();
    bus_if.ena = 1'b1;
    write_tap(5, W'(7), 0);
    n_cmp++; if (bus_if.addr_err !== 1'b1) begin n_err++; $display("FAIL addr_err_set: got %b want 1", bus_if.addr_err); end
    pulse_commit(1'b1);
    wait_update(10, seen, cyc);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL addr_err_swap: no coef_update seen, want one"); end
    if (seen && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      active_model = exp_v;
      n_cmp++; if (bus_if.coeff_concat !== exp_v) begin n_err++; $display("FAIL addr_err_shadow: got %h want %h", bus_if.coeff_concat, exp_v); end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus_if.addr_err !== 1'b1) begin n_err++; $display("FAIL addr_err_sticky: got %b want 1", bus_if.addr_err); end
  endtask

  task automatic test_write_in_pend();
    pulse_commit(1'b0);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = AW'(2);
    bus_if.wr_data = W'(55);
    @(negedge clk);
    bus_if.wr_en   = 1'b0;
    bus_if.ena     = 1'b1;
    wait_update(10, seen, cyc);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL pend_write_swap: no coef_update seen, want one"); end
    if (seen && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      active_model = exp_v;
      n_cmp++; if (bus_if.coeff_concat[2*W +: W] !== W'(300)) begin n_err++; $display("FAIL pend_write_tap2: got %h want %h", bus_if.coeff_concat[2*W +: W], W'(300)); end
      n_cmp++; if (bus_if.coeff_concat !== exp_v) begin n_err++; $display("FAIL pend_write_coeff: got %h want %h", bus_if.coeff_concat, exp_v); end
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = AW'(1);
    bus_if.wr_data = W'(9);
    bus_if.commit  = 1'b1;
    bus_if.ena     = 1'b1;
    sh[1] = W'(9);
    exp_q.push_back(pack_model());
    @(negedge clk);
    bus_if.wr_en  = 1'b0;
    bus_if.commit = 1'b0;
    wait_update(10, seen, cyc);
    n_cmp++;
    if (!seen || cyc != 1) begin n_err++; $display("FAIL same_cycle_latency: seen=%b cycles=%0d want seen=1 cycles=1", seen, cyc); end
    if (seen && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      active_model = exp_v;
      n_cmp++; if (bus_if.coeff_concat[W +: W] !== W'(9)) begin n_err++; $display("FAIL same_cycle_tap1: got %h want 0009", bus_if.coeff_concat[W +: W]); end
      n_cmp++; if (bus_if.coeff_concat !== exp_v) begin n_err++; $display("FAIL same_cycle_coeff: got %h want %h", bus_if.coeff_concat, exp_v); end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    write_tap(3, W'(1234), 1);
    pulse_commit(1'b0);
    // Extra commits while busy must not queue a second swap.
    bus_if.commit = 1'b1;
    repeat (2) @(negedge clk);
    bus_if.commit = 1'b0;
    bus_if.ena    = 1'b1;
    wait_update(10, seen, cyc);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL b2b_swap: no coef_update seen, want one"); end
    if (seen && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      active_model = exp_v;
      n_cmp++; if (bus_if.coeff_concat !== exp_v) begin n_err++; $display("FAIL b2b_coeff: got %h want %h", bus_if.coeff_concat, exp_v); end
    end
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.coef_update === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL b2b_ignored_commit: got %0d extra pulses want 0", pulses); end
    // Re-commit with no writes: retained shadow gives the same bank again.
    pulse_commit(1'b1);
    wait_update(10, seen, cyc);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL b2b_recommit: no coef_update seen, want one"); end
    if (seen && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      active_model = exp_v;
      n_cmp++; if (bus_if.coeff_concat !== exp_v) begin n_err++; $display("FAIL b2b_retained: got %h want %h", bus_if.coeff_concat, exp_v); end
    end
  endtask

  task automatic test_reset_in_pend();
    int pulses;
    pulse_commit(1'b0);
    n_cmp++; if (bus_if.busy !== 1'b1) begin n_err++; $display("FAIL rst_pend_busy: got %b want 1", bus_if.busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NT; i++) sh[i] = '0;
    active_model = '0;
    n_cmp++; if (bus_if.coeff_concat !== '0) begin n_err++; $display("FAIL rst_pend_coeff: got %h want 0", bus_if.coeff_concat); end
    n_cmp++; if (bus_if.busy !== 1'b0) begin n_err++; $display("FAIL rst_pend_busy_clr: got %b want 0", bus_if.busy); end
    n_cmp++; if (bus_if.coef_valid !== 1'b0) begin n_err++; $display("FAIL rst_pend_valid: got %b want 0", bus_if.coef_valid); end
    n_cmp++; if (bus_if.addr_err !== 1'b0) begin n_err++; $display("FAIL rst_pend_addr_err: got %b want 0", bus_if.addr_err); end
    bus_if.ena = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.coef_update === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rst_pend_abort: got %0d pulses want 0", pulses); end
`ifdef FIR_COEF_READBACK_EN
    bus_if.rd_en   = 1'b1;
    bus_if.rd_addr = AW'(0);
    @(negedge clk);
    bus_if.rd_en   = 1'b0;
    n_cmp++; if (bus_if.rd_data !== '0) begin n_err++; $display("FAIL rst_pend_readback: got %h want 0", bus_if.rd_data); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_swap();
`ifdef FIR_COEF_READBACK_EN
    test_readback();
`endif
    test_ena_stall();
    test_addr_err();
    test_write_in_pend();
    test_same_cycle();
    test_back_to_back();
    test_reset_in_pend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
